// File: rtl/permute_ctrl_if.sv
// Start/done handshake and result-memory write port between the encoder top level,
// the permutation datapath and permute_ctrl.
interface permute_ctrl_if #(
    parameter int AW = 6
);
    logic          start;
    logic          all_done;
    logic          read_mem;
    logic          start_instances;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic          error;

    // Encoder top level / datapath side.
    modport master (
        output start,
        output all_done,
        input  read_mem,
        input  start_instances,
        input  wr_en,
        input  wr_addr,
        input  busy,
        input  done,
        input  error
    );

    // Controller side.
    modport slave (
        input  start,
        input  all_done,
        output read_mem,
        output start_instances,
        output wr_en,
        output wr_addr,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/permute_ctrl.sv
// Sequencer for the 64-lane permutation datapath: load, launch, wait for the combined
// ready flag under a watchdog, then stream one result lane per cycle to the result memory.
module permute_ctrl #(
    parameter int LANES   = 64,
    parameter int AW      = 6,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    permute_ctrl_if.slave ctrl
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_SETTLE,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [TW-1:0] r_wd;
    logic [TW-1:0] w_wd_inc;
    logic          w_timeout;
    logic [AW-1:0] r_wr_addr;
    logic [AW-1:0] w_wr_addr_next;
    logic          w_last_lane;

    logic          r_read_mem;
    logic          r_start_instances;
    logic          r_wr_en;
    logic          r_busy;
    logic          r_done;
    logic          r_error;

    assign w_wd_inc    = r_wd + TW'(1);
    assign w_timeout   = (w_wd_inc == TW'(TIMEOUT));
    assign w_last_lane = (r_wr_addr == AW'(LANES - 1));

    // NOTE: state and every registered output use non-blocking assignments so all
    // flops sample the same pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the next state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (ctrl.start) w_next_state = S_LOAD;
            S_LOAD:   w_next_state = S_KICK;
            S_KICK:   w_next_state = S_SETTLE;
            S_SETTLE: w_next_state = S_WAIT;
            // A ready flag on the final watchdog cycle still counts as completion.
            S_WAIT: begin
                if (ctrl.all_done)  w_next_state = S_WRITE;
                else if (w_timeout) w_next_state = S_ERR;
            end
            S_WRITE:  if (w_last_lane) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            S_ERR:    if (ctrl.start) w_next_state = S_LOAD;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr_addr_next = '0;
        if (w_next_state == S_WRITE && r_state == S_WRITE) begin
            w_wr_addr_next = r_wr_addr + AW'(1);
        end
    end

    // Moore outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd              <= '0;
            r_wr_addr         <= '0;
            r_read_mem        <= 1'b0;
            r_start_instances <= 1'b0;
            r_wr_en           <= 1'b0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_error           <= 1'b0;
        end else begin
            if (r_state == S_KICK) begin
                r_wd <= '0;
            end else if (r_state == S_WAIT && !ctrl.all_done) begin
                r_wd <= w_wd_inc;
            end
            r_wr_addr         <= w_wr_addr_next;
            r_read_mem        <= (w_next_state == S_LOAD);
            r_start_instances <= (w_next_state == S_KICK);
            r_wr_en           <= (w_next_state == S_WRITE);
            r_busy            <= (w_next_state != S_IDLE) && (w_next_state != S_ERR);
            r_done            <= (w_next_state == S_DONE);
            r_error           <= (w_next_state == S_ERR);
        end
    end

    assign ctrl.read_mem        = r_read_mem;
    assign ctrl.start_instances = r_start_instances;
    assign ctrl.wr_en           = r_wr_en;
    assign ctrl.wr_addr         = r_wr_addr;
    assign ctrl.busy            = r_busy;
    assign ctrl.done            = r_done;
    assign ctrl.error           = r_error;

endmodule

// File: tb/tb_permute_ctrl.sv
// Self-checking bench for permute_ctrl: an edge-numbered timing model compared every
// cycle, plus directed scenarios with hand-computed edge numbers and counts.
module tb_permute_ctrl;
    localparam int LANES   = 64;
    localparam int AW      = 6;
    localparam int TIMEOUT = 1023;
    localparam int TW      = 10;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    bit   cmp_en = 0;
    int   edge_n = 0;

    permute_ctrl_if #(.AW(AW)) bus ();

    permute_ctrl #(
        .LANES  (LANES),
        .AW     (AW),
        .TIMEOUT(TIMEOUT),
        .TW     (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctrl(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a run is described only by its start edge s and the edge k at which the
    // ready flag was accepted; every output follows from edge offsets against those.
    bit m_run = 0;
    bit m_err = 0;
    int m_s   = 0;
    int m_k   = -1;
    int m_cyc = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_run = 0;
            m_err = 0;
            m_s   = 0;
            m_k   = -1;
            m_cyc = 0;
        end else begin
            m_cyc++;
            if (m_run) begin
                if (m_k < 0) begin
                    if (m_cyc >= m_s + 4) begin
                        if (bus.all_done) begin
                            m_k = m_cyc;
                        end else if (m_cyc - (m_s + 3) >= TIMEOUT) begin
                            m_run = 0;
                            m_err = 1;
                        end
                    end
                end else if (m_cyc == m_k + LANES + 1) begin
                    m_run = 0;
                end
            end else if (bus.start) begin
                m_run = 1;
                m_s   = m_cyc;
                m_k   = -1;
                m_err = 0;
            end
        end
    end

    function automatic logic [31:0] act_outs();
        return {20'd0, bus.read_mem, bus.start_instances, bus.wr_en, bus.wr_addr,
                bus.done, bus.busy, bus.error};
    endfunction

    function automatic logic [31:0] exp_outs();
        logic          rd, si, wr, dn;
        logic [AW-1:0] a;
        rd = m_run && (m_cyc == m_s);
        si = m_run && (m_cyc == m_s + 1);
        wr = m_run && (m_k >= 0) && (m_cyc <= m_k + LANES - 1);
        a  = wr ? AW'(m_cyc - m_k) : '0;
        dn = m_run && (m_k >= 0) && (m_cyc == m_k + LANES);
        return {20'd0, rd, si, wr, a, dn, m_run, m_err};
    endfunction

    initial forever begin
        @(negedge clk);
        if (cmp_en) check("cycle_cmp", act_outs(), exp_outs());
    end

    // Event monitor feeding the directed checks.
    int rd_cnt, wr_cnt, done_cnt, ord_bad, run_wr;
    int first_wr_edge, done_edge, done_edge_first, rd_edge2, err_edge;

    task automatic clear_stats();
        rd_cnt          = 0;
        wr_cnt          = 0;
        done_cnt        = 0;
        ord_bad         = 0;
        first_wr_edge   = -1;
        done_edge       = -1;
        done_edge_first = -1;
        rd_edge2        = -1;
        err_edge        = -1;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            run_wr = 0;
        end else begin
            if (bus.read_mem) begin
                rd_cnt++;
                if (rd_cnt == 2) rd_edge2 = edge_n;
            end
            if (bus.wr_en) begin
                if (first_wr_edge < 0) first_wr_edge = edge_n;
                if (bus.wr_addr != AW'(run_wr)) ord_bad++;
                run_wr++;
                wr_cnt++;
            end else begin
                run_wr = 0;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) done_edge_first = edge_n;
                done_edge = edge_n;
            end
            if (bus.error && err_edge < 0) err_edge = edge_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Pulses start for one sampling edge and returns that edge number.
    task automatic pulse_start(output int e0);
        bus.start = 1'b1;
        tick();
        e0 = edge_n;
        bus.start = 1'b0;
    endtask

    task automatic tick_to(input int target);
        for (int i = 0; i < 4000 && edge_n < target; i++) tick();
    endtask

    task automatic wait_idle(input string name, input int limit);
        for (int i = 0; i < limit && bus.busy; i++) tick();
        settle();
        check(name, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int e0;
        int e1;
        int snap;
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected stopped");
        $fatal(1, "global timeout");
    end

    initial begin
        int e0;
        int e1;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.all_done = 1'b0;
        clear_stats();
        reset_dut();
        cmp_en = 1;
        check("reset_state", act_outs(), 32'd0);

        // Nominal run: ready accepted at edge 20, writes 20..83, done after edge 84.
        clear_stats();
        pulse_start(e0);
        check("nom_read_mem", 32'(bus.read_mem), 32'd1);
        tick_to(e0 + 19);
        bus.all_done = 1'b1;
        tick();
        check("nom_first_wr_en", 32'(bus.wr_en), 32'd1);
        tick_to(e0 + 50);
        bus.all_done = 1'b0;
        wait_idle("nom_idle", 200);
        check("nom_rd_cnt", rd_cnt, 1);
        check("nom_wr_cnt", wr_cnt, 64);
        check("nom_order", ord_bad, 0);
        check("nom_first_wr", first_wr_edge - e0, 20);
        check("nom_done_edge", done_edge - e0, 84);
        check("nom_done_cnt", done_cnt, 1);
        check("nom_error", 32'(bus.error), 32'd0);

        // Stale ready flag held through LOAD/KICK/SETTLE: first write at edge 4.
        clear_stats();
        bus.all_done = 1'b1;
        pulse_start(e0);
        wait_idle("stale_idle", 200);
        check("stale_first_wr", first_wr_edge - e0, 4);
        check("stale_wr_cnt", wr_cnt, 64);
        check("stale_done_edge", done_edge - e0, 68);
        bus.all_done = 1'b0;

        // Watchdog: error at edge 1026, no writes.
        clear_stats();
        pulse_start(e0);
        for (int i = 0; i < 1100 && !bus.error; i++) tick();
        settle();
        check("to_err_edge", err_edge - e0, 1026);
        check("to_busy", 32'(bus.busy), 32'd0);
        check("to_wr_cnt", wr_cnt, 0);
        // Restart from ERR; ready arrives exactly on the timeout edge.
        clear_stats();
        tick();
        pulse_start(e1);
        check("to_restart_read_mem", 32'(bus.read_mem), 32'd1);
        check("to_restart_error", 32'(bus.error), 32'd0);
        tick_to(e1 + 1025);
        check("to_edge_minus1_error", 32'(bus.error), 32'd0);
        bus.all_done = 1'b1;
        tick();
        check("to_tie_wr_en", 32'(bus.wr_en), 32'd1);
        check("to_tie_error", 32'(bus.error), 32'd0);
        bus.all_done = 1'b0;
        wait_idle("to_tie_idle", 200);
        check("to_tie_wr_cnt", wr_cnt, 64);

        // Start pulses during WAIT and WRITE are ignored; all_done drops mid-write.
        clear_stats();
        pulse_start(e0);
        tick_to(e0 + 10);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick_to(e0 + 14);
        bus.all_done = 1'b1;
        tick();
        tick_to(e0 + 39);
        bus.start    = 1'b1;
        bus.all_done = 1'b0;
        tick();
        bus.start = 1'b0;
        wait_idle("busy_idle", 200);
        check("busy_rd_cnt", rd_cnt, 1);
        check("busy_wr_cnt", wr_cnt, 64);
        check("busy_first_wr", first_wr_edge - e0, 15);
        check("busy_done_edge", done_edge - e0, 79);

        // Back-to-back with start held high: next LOAD two edges after done's edge.
        clear_stats();
        bus.all_done = 1'b1;
        bus.start    = 1'b1;
        tick();
        e0 = edge_n;
        for (int i = 0; i < 400 && done_cnt < 2; i++) tick();
        bus.start = 1'b0;
        wait_idle("b2b_idle", 200);
        check("b2b_done_first", done_edge_first - e0, 68);
        check("b2b_restart_gap", rd_edge2 - done_edge_first, 2);
        check("b2b_rd_cnt", rd_cnt, 2);
        check("b2b_wr_cnt", wr_cnt, 128);
        check("b2b_order", ord_bad, 0);

        // Reset in the middle of write-out at lane 30.
        clear_stats();
        pulse_start(e0);
        for (int i = 0; i < 100 && !(bus.wr_en && bus.wr_addr == AW'(30)); i++) tick();
        rst = 1'b1;
        #1;
        check("rst_async_outs", act_outs(), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        settle();
        check("rst_wr_cnt", wr_cnt, 30);
        check("rst_busy", 32'(bus.busy), 32'd0);
        clear_stats();
        tick();
        pulse_start(e0);
        check("rst_restart_read_mem", 32'(bus.read_mem), 32'd1);
        wait_idle("rst_restart_idle", 200);
        check("rst_restart_first_wr", first_wr_edge - e0, 4);
        check("rst_restart_wr_cnt", wr_cnt, 64);
        check("rst_restart_order", ord_bad, 0);
        bus.all_done = 1'b0;

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
